// File: rtl/jpeg_pkg.sv
// Shared constants for the block pipeline (loader, encoder, decoder).
// Provides the element width, the block dimension, the flat block width and
// the state encoding of the loader's launch FSM.
package jpeg_pkg;
  localparam int DATA_W     = 8;
  localparam int N          = 8;
  localparam int BLOCK_BITS = N * N * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } launch_st_e;
endpackage

// File: rtl/pp_bank.sv
// One half of the ping-pong store: NE elements of EW bits.
// Ports: clk/rst (sync, active high), clr zeroes the whole bank, we/widx/wdata
// write one element, q is the flat read-out (element k at [EW*k +: EW]).
module pp_bank #(
  parameter int EW    = 8,
  parameter int NE    = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [EW-1:0]    wdata,
  output logic [NE*EW-1:0] q
);
  import jpeg_pkg::*;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (we) begin
      for (int k = 0; k < NE; k++)
        if (widx == IDX_W'(k)) q[k*EW +: EW] <= wdata;
    end
  end
endmodule

// File: rtl/block_loader.sv
// Collects a serial element stream into NxN blocks, ping-pong buffered, and
// presents each complete block to the encoder as one flat vector.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_valid/s_data/s_last     element stream in (row-major), optional end marker
//   s_ready                   element accepted when s_valid & s_ready
//   blk_data                  flat block, element k at [DATA_W*k +: DATA_W]
//   blk_en / blk_done         encoder handshake: level enable, held until done
//   err_short                 one-cycle pulse when s_last closes a block early
//   blk_cnt                   blocks released by blk_done (wrapping)
module block_loader #(
  parameter int DATA_W = 8,
  parameter int N      = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [N*N*DATA_W-1:0] blk_data,
  output logic                  blk_en,
  input  logic                  blk_done,
  output logic                  err_short,
  output logic [CNT_W-1:0]      blk_cnt
);
  import jpeg_pkg::*;

  localparam int NE    = N * N;
  localparam int IDX_W = $clog2(NE);
  localparam int BB    = NE * DATA_W;

  logic [IDX_W-1:0]   idx;
  logic               wbank, rbank;
  logic [1:0]         full;
  launch_st_e         st;
  logic [1:0][BB-1:0] bank_q;
  logic               acc, close, rel;
  logic [1:0]         set_full, clr_full;

  assign s_ready  = ~rst & ~full[wbank];
  assign acc      = s_valid & s_ready;
  assign close    = acc & (s_last | (idx == IDX_W'(NE-1)));
  assign rel      = (st == ST_RUN) & blk_done;
  assign blk_data = bank_q[rbank];

  // A bank is never closed and released on the same edge: closing needs it
  // empty, release needs it full.
  genvar g;
  for (g = 0; g < 2; g++) begin : g_bank
    assign set_full[g] = close & (wbank == 1'(g));
    assign clr_full[g] = rel & (rbank == 1'(g));
    pp_bank #(.EW(DATA_W), .NE(NE), .IDX_W(IDX_W)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_full[g]),
      .we    (acc & (wbank == 1'(g))),
      .widx  (idx),
      .wdata (s_data),
      .q     (bank_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      full      <= '0;
      st        <= ST_IDLE;
      blk_en    <= 1'b0;
      err_short <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      err_short <= close & s_last & (idx != IDX_W'(NE-1));
      full      <= (full | set_full) & ~clr_full;

      if (acc) begin
        if (close) begin
          idx   <= '0;
          wbank <= ~wbank;
        end else begin
          idx <= idx + 1'b1;
        end
      end

      case (st)
        ST_IDLE: if (full[rbank]) begin
          st     <= ST_RUN;
          blk_en <= 1'b1;
        end
        ST_RUN: if (blk_done) begin
          st      <= ST_GAP;
          blk_en  <= 1'b0;
          rbank   <= ~rbank;
          blk_cnt <= blk_cnt + 1'b1;
        end
        ST_GAP: st <= ST_IDLE;
        default: begin
          st     <= ST_IDLE;
          blk_en <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_block_loader.sv
module tb_block_loader;
  logic         clk = 1'b0;
  logic         rst, s_valid, s_last, s_ready, blk_en, blk_done, err_short;
  logic [7:0]   s_data;
  logic [511:0] blk_data;
  logic [15:0]  blk_cnt;

  always #5 clk = ~clk;

  block_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .blk_data  (blk_data),
    .blk_en    (blk_en),
    .blk_done  (blk_done),
    .err_short (err_short),
    .blk_cnt   (blk_cnt)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: a queue of closed blocks (front = block offered to the
  // encoder), the block being assembled, and the launch timing.
  logic [511:0] fq[$];
  logic [511:0] cur;
  int           idx;
  logic         m_en, m_gap, m_err;
  logic [15:0]  m_cnt;
  logic         dut_rdy;

  task automatic model_edge(input logic r, input logic v, input logic l, input logic dn,
                            input logic [7:0] d);
    logic rdy, rel, start;
    if (r) begin
      fq.delete(); cur = '0; idx = 0;
      m_en = 0; m_gap = 0; m_err = 0; m_cnt = 0;
      return;
    end
    rdy   = fq.size() < 2;
    rel   = m_en && dn;
    start = !m_en && !m_gap && fq.size() > 0;
    m_err = 0;
    if (v && rdy) begin
      cur[8*idx +: 8] = d;
      idx++;
      if (l || idx == 64) begin
        m_err = (idx < 64);
        fq.push_back(cur);
        cur = '0;
        idx = 0;
      end
    end
    if (rel) begin
      void'(fq.pop_front());
      m_cnt++;
      m_en  = 0;
      m_gap = 1;
    end else if (m_gap) m_gap = 0;
    else if (start) m_en = 1;
  endtask

  task automatic step(input logic r, input logic v, input logic l, input logic dn,
                      input logic [7:0] d);
    rst = r; s_valid = v; s_last = l; blk_done = dn; s_data = d;
    #1;
    dut_rdy = s_ready;
    chk("s_ready", s_ready, !r && fq.size() < 2);
    @(posedge clk);
    model_edge(r, v, l, dn, d);
    #1;
    chk("blk_en", blk_en, m_en);
    chk("blk_data", blk_data, fq.size() > 0 ? fq[0] : cur);
    chk("err_short", err_short, m_err);
    chk("blk_cnt", blk_cnt, m_cnt);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 8'h00);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    step(0, 1, l, 0, d);
  endtask

  task automatic wait_launch(input string nm);
    for (int i = 0; i < 20 && !blk_en; i++) idle();
    chk(nm, blk_en, 1'b1);
  endtask

  function automatic logic [511:0] mk_blk(input int len, input logic [7:0] base, input bit inc);
    logic [511:0] b = '0;
    for (int k = 0; k < len; k++) b[8*k +: 8] = inc ? base + 8'(k) : base;
    return b;
  endfunction

  typedef struct {
    int           len;
    logic [7:0]   base;
    logic         last;
    logic         exp_err;
    logic [511:0] exp_blk;
  } vec_t;

  initial begin
    vec_t         tbl[5];
    logic [511:0] sent[$], got[$];
    logic [511:0] blk;
    int           acc_n, nb, age;
    logic         prev_en, v, dn;
    logic [7:0]   d;

    tbl[0] = '{64, 8'h10, 1'b0, 1'b0, mk_blk(64, 8'h10, 1)};
    tbl[1] = '{64, 8'h40, 1'b1, 1'b0, mk_blk(64, 8'h40, 1)};
    tbl[2] = '{1,  8'hA5, 1'b1, 1'b1, mk_blk(1,  8'hA5, 1)};
    tbl[3] = '{63, 8'h01, 1'b1, 1'b1, mk_blk(63, 8'h01, 1)};
    tbl[4] = '{20, 8'h30, 1'b1, 1'b1, mk_blk(20, 8'h30, 1)};

    // Reset state, then the first 64-element block.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_en", blk_en, 1'b0);
    chk("rst_data", blk_data, '0);
    chk("rst_cnt", blk_cnt, 16'd0);
    for (int k = 0; k < 64; k++) send(8'(k), 0);
    chk("t1_en_not_yet", blk_en, 1'b0);
    idle();
    chk("t1_en", blk_en, 1'b1);
    chk("t1_lo", blk_data[7:0], 8'h00);
    chk("t1_hi", blk_data[511:504], 8'h3F);

    // Second block fills the other bank; both full blocks the stream.
    acc_n = 0;
    for (int k = 0; k < 64; k++) begin
      send(8'h80 + 8'(k), 0);
      acc_n += int'(dut_rdy);
    end
    chk("t2_acc", acc_n, 64);
    send(8'hC0, 0);
    chk("t2_blocked", dut_rdy, 1'b0);
    chk("t2_hold", blk_data, mk_blk(64, 8'h00, 1));

    // Release: gap, then relaunch of the second block.
    step(0, 0, 0, 1, 0);
    chk("t3_cnt", blk_cnt, 16'd1);
    chk("t3_en_low", blk_en, 1'b0);
    chk("t3_ready", s_ready, 1'b1);
    idle();
    chk("t3_en_low2", blk_en, 1'b0);
    idle();
    chk("t3_relaunch", blk_en, 1'b1);
    chk("t3_data", blk_data[7:0], 8'h80);

    // Short block: 10 elements then s_last.
    for (int k = 0; k < 10; k++) send(8'hFF, k == 9);
    chk("t4_err", err_short, 1'b1);
    idle();
    chk("t4_err_end", err_short, 1'b0);
    step(0, 0, 0, 1, 0);
    wait_launch("t4_launch");
    chk("t4_short", blk_data, mk_blk(10, 8'hFF, 0));

    // Reset while running with the other bank half filled.
    for (int k = 0; k < 32; k++) send(8'(k * 3), 0);
    step(1, 0, 0, 0, 0);
    chk("t5_en", blk_en, 1'b0);
    chk("t5_data", blk_data, '0);
    chk("t5_cnt", blk_cnt, 16'd0);
    blk = '0;
    for (int k = 0; k < 64; k++) begin
      d = 8'($urandom);
      blk[8*k +: 8] = d;
      send(d, 0);
    end
    wait_launch("t5_launch");
    chk("t5_fresh", blk_data, blk);
    step(0, 0, 0, 1, 0);

    // Table of block shapes, including s_last on the final element.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < tbl[i].len; k++)
        send(tbl[i].base + 8'(k), tbl[i].last && (k == tbl[i].len - 1));
      chk("tbl_err", err_short, tbl[i].exp_err);
      wait_launch("tbl_launch");
      chk("tbl_blk", blk_data, tbl[i].exp_blk);
      step(0, 0, 0, 1, 0);
    end
    chk("tbl_cnt", blk_cnt, 16'd5);

    // Back-to-back: four blocks, done three cycles after each launch.
    step(1, 0, 0, 0, 0);
    nb = 0; age = 0; prev_en = 0; blk = '0;
    for (int i = 0; i < 3000 && !(got.size() == 4 && blk_cnt == 16'd4); i++) begin
      v  = (nb < 256) && ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      dn = blk_en && (age == 3);
      step(0, v, 0, dn, d);
      if (v && dut_rdy) begin
        blk[8*(nb % 64) +: 8] = d;
        nb++;
        if (nb % 64 == 0) sent.push_back(blk);
      end
      if (blk_en && !prev_en) got.push_back(blk_data);
      age     = blk_en ? age + 1 : 0;
      prev_en = blk_en;
    end
    chk("b2b_cnt", blk_cnt, 16'd4);
    chk("b2b_bytes", nb, 256);
    chk("b2b_nblk", got.size(), 4);
    for (int j = 0; j < 4; j++)
      chk("b2b_order", j < got.size() ? got[j] : 'x, j < sent.size() ? sent[j] : '0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 400) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 5) == 0, 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
